// File: rtl/lcd_8080_writer_if.sv
// Bundles the upstream word handshake and the panel-side 8080 conduit pins of lcd_8080_writer.
// The slave modport is the writer itself; the master modport is the side that feeds it words.
interface lcd_8080_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_is_cmd;
  logic        panel_reset_req;
  logic        busy;
  logic        lcd_cs;
  logic        lcd_wr;
  logic        lcd_rd;
  logic        lcd_c_d;
  logic [15:0] lcd_data;
  logic        lcd_res;
  logic        lcd_im0;

  modport master (
    output in_valid, in_data, in_is_cmd, panel_reset_req,
    input  in_ready, busy, lcd_cs, lcd_wr, lcd_rd, lcd_c_d, lcd_data, lcd_res, lcd_im0
  );

  modport slave (
    input  in_valid, in_data, in_is_cmd, panel_reset_req,
    output in_ready, busy, lcd_cs, lcd_wr, lcd_rd, lcd_c_d, lcd_data, lcd_res, lcd_im0
  );
endinterface

// File: rtl/lcd_8080_writer.sv
// 8080-style 16-bit LCD write front end: turns accepted command/data words into timed
// CS/WR/C_D/DATA cycles and sequences the panel hardware reset on RES.
module lcd_8080_writer #(
  parameter int unsigned CS_SETUP_CYCLES   = 1,
  parameter int unsigned WR_LOW_CYCLES     = 2,
  parameter int unsigned WR_HIGH_CYCLES    = 2,
  parameter int unsigned CS_IDLE_CYCLES    = 4,
  parameter int unsigned RESET_LOW_CYCLES  = 500,
  parameter int unsigned RESET_WAIT_CYCLES = 6000,
  parameter logic        IM0_VALUE         = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  lcd_8080_writer_if.slave bus
);

  localparam logic [15:0] CS_SETUP_N   = 16'(CS_SETUP_CYCLES);
  localparam logic [15:0] WR_LOW_N     = 16'(WR_LOW_CYCLES);
  localparam logic [15:0] WR_HIGH_N    = 16'(WR_HIGH_CYCLES);
  localparam logic [15:0] CS_IDLE_N    = 16'(CS_IDLE_CYCLES);
  localparam logic [15:0] RESET_LOW_N  = 16'(RESET_LOW_CYCLES);
  localparam logic [15:0] RESET_WAIT_N = 16'(RESET_WAIT_CYCLES);

  typedef enum logic [2:0] {
    RST_LOW, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH, HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic        res_q, res_d;
  logic        cd_q, cd_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        pend_q, pend_d;

  logic        rst_req;
  logic        accept;
  logic        cnt_last;
  logic        take_rst;

  always_comb begin
    rst_req  = pend_q | bus.panel_reset_req;
    // A reset request arriving in the same cycle as a valid word wins over the word.
    accept   = bus.in_valid & ready_q & ~bus.panel_reset_req;
    cnt_last = (cnt_q <= 16'd1);
    take_rst = 1'b0;

    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    cs_d     = cs_q;
    wr_d     = wr_q;
    res_d    = res_q;
    cd_d     = cd_q;
    pend_d   = rst_req;

    case (state_q)
      RST_LOW: begin
        pend_d = 1'b0;
        if (bus.panel_reset_req) begin
          take_rst = 1'b1;
        end else if (cnt_last) begin
          state_d = RST_WAIT;
          cnt_d   = RESET_WAIT_N;
          res_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RST_WAIT: begin
        pend_d = 1'b0;
        if (bus.panel_reset_req) begin
          take_rst = 1'b1;
        end else if (cnt_last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      IDLE: begin
        if (rst_req) begin
          take_rst = 1'b1;
        end else if (accept) begin
          state_d = SETUP;
          cnt_d   = CS_SETUP_N;
          data_d  = bus.in_data;
          cd_d    = ~bus.in_is_cmd;
        end
      end
      // CS drops on the first SETUP cycle, so WR falls CS_SETUP cycles after CS.
      SETUP: begin
        cs_d = 1'b0;
        if (cnt_q == 16'd0) begin
          state_d = WR_LOW;
          wr_d    = 1'b0;
          cnt_d   = WR_LOW_N;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      WR_LOW: begin
        if (cnt_last) begin
          state_d = WR_HIGH;
          wr_d    = 1'b1;
          cnt_d   = WR_HIGH_N;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      WR_HIGH: begin
        if (cnt_last) begin
          if (rst_req) begin
            take_rst = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = CS_IDLE_N;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      HOLD: begin
        if (rst_req) begin
          take_rst = 1'b1;
        end else if (accept) begin
          state_d = WR_LOW;
          wr_d    = 1'b0;
          cnt_d   = WR_LOW_N;
          data_d  = bus.in_data;
          cd_d    = ~bus.in_is_cmd;
        end else if (cnt_last) begin
          state_d = IDLE;
          cs_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: take_rst = 1'b1;
    endcase

    if (take_rst) begin
      state_d = RST_LOW;
      cnt_d   = RESET_LOW_N;
      res_d   = 1'b0;
      cs_d    = 1'b1;
      wr_d    = 1'b1;
      pend_d  = 1'b0;
    end

    ready_d = ((state_d == IDLE) || (state_d == HOLD)) && !pend_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_LOW;
      cnt_q   <= RESET_LOW_N;
      data_q  <= 16'h0000;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      res_q   <= 1'b0;
      cd_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      res_q   <= res_d;
      cd_q    <= cd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.lcd_cs   = cs_q;
  assign bus.lcd_wr   = wr_q;
  assign bus.lcd_rd   = 1'b1;
  assign bus.lcd_c_d  = cd_q;
  assign bus.lcd_data = data_q;
  assign bus.lcd_res  = res_q;
  assign bus.lcd_im0  = IM0_VALUE;

endmodule

// File: tb/tb_lcd_8080_writer.sv
// Directed bench for lcd_8080_writer: a scoreboard of accepted words is checked against
// every WR rising edge, alongside cycle-accurate checks of CS/WR/RES timing.
module tb_lcd_8080_writer;

  logic clk;
  logic reset_n;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  lcd_8080_writer_if bus ();

  lcd_8080_writer #(
    .RESET_LOW_CYCLES (10),
    .RESET_WAIT_CYCLES(20)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        cd;
  } exp_t;

  exp_t        sb[$];
  int          falls[$];
  int          wr_fall_cyc = -1;
  int          wr_rise_cyc = -1;
  int          cs_fall_cyc = -1;
  int          cs_rise_cyc = -1;
  int          cs_rises    = 0;
  logic [15:0] fall_data;
  logic        prev_wr = 1'b1;
  logic        prev_cs = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Panel-side monitor: edge detection on CS/WR, sampled on the falling clock edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset_n) begin
      prev_wr = 1'b1;
      prev_cs = 1'b1;
    end else begin
      chk("wr_low_while_cs_high", 32'(bus.lcd_cs & ~bus.lcd_wr), 0);
      if (prev_cs && !bus.lcd_cs) cs_fall_cyc = cyc;
      if (!prev_cs && bus.lcd_cs) begin
        cs_rise_cyc = cyc;
        cs_rises++;
      end
      if (prev_wr && !bus.lcd_wr) begin
        wr_fall_cyc = cyc;
        falls.push_back(cyc);
        fall_data = bus.lcd_data;
      end
      if (!prev_wr && bus.lcd_wr) begin
        wr_rise_cyc = cyc;
        chk("wr_low_width", cyc - wr_fall_cyc, 2);
        chk("data_stable", 32'(bus.lcd_data), 32'(fall_data));
        tests++;
        assert (sb.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_write: observed data %0h, expected no write", bus.lcd_data);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_data", 32'(bus.lcd_data), 32'(e.d));
          chk("sb_c_d", 32'(bus.lcd_c_d), 32'(e.cd));
        end
      end
      prev_wr = bus.lcd_wr;
      prev_cs = bus.lcd_cs;
    end
  end

  function automatic logic cond(input int sel);
    case (sel)
      0:       return bus.in_ready;
      1:       return !bus.busy;
      default: return !bus.lcd_wr;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (n < 200 && !cond(sel)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 200), 1);
  endtask

  // Called on a falling edge; returns on the falling edge right after the accepting edge.
  task automatic send(input logic [15:0] d, input logic is_cmd, output int acc);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_is_cmd = is_cmd;
    while (n < 200 && !bus.in_ready) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 200), 1);
    sb.push_back('{d: d, cd: ~is_cmd});
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic measure_reset(input int r, input string tag);
    int res_cyc = -1;
    int rdy_cyc = -1;
    logic cs_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.lcd_res && res_cyc < 0) res_cyc = cyc;
      if (bus.in_ready && rdy_cyc < 0) rdy_cyc = cyc;
      if (!bus.lcd_cs) cs_low = 1'b1;
    end
    chk({tag, "_res_rise"}, res_cyc - r, 10);
    chk({tag, "_ready_rise"}, rdy_cyc - r, 30);
    chk({tag, "_cs_high"}, 32'(cs_low), 0);
  endtask

  initial begin
    int a, a2, r, f, c0, nf0, res_cyc, rdy_cyc;
    logic cs_at_res;
    reset_n             = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_data         = 16'h0000;
    bus.in_is_cmd       = 1'b0;
    bus.panel_reset_req = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_res", 32'(bus.lcd_res), 0);
    chk("rst_cs", 32'(bus.lcd_cs), 1);
    chk("rst_wr", 32'(bus.lcd_wr), 1);
    chk("rst_rd", 32'(bus.lcd_rd), 1);
    chk("rst_c_d", 32'(bus.lcd_c_d), 1);
    chk("rst_data", 32'(bus.lcd_data), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("im0", 32'(bus.lcd_im0), 1);

    // Power-up sequence
    r = cyc;
    reset_n = 1'b1;
    measure_reset(r, "pu");
    chk("idle_busy", 32'(bus.busy), 0);

    // Single command 0x2C
    send(16'h002C, 1'b1, a);
    bus.in_valid = 1'b0;
    wait_for(1, "single_done");
    chk("single_cs_fall", cs_fall_cyc - a, 1);
    chk("single_wr_fall", wr_fall_cyc - a, 2);
    chk("single_wr_rise", wr_rise_cyc - a, 4);
    chk("single_cs_rise", cs_rise_cyc - a, 10);
    chk("single_hold_c_d", 32'(bus.lcd_c_d), 0);
    chk("single_hold_data", 32'(bus.lcd_data), 32'h2C);
    chk("single_sb_empty", sb.size(), 0);

    // Burst of four data words with in_valid held high
    c0  = cs_rises;
    nf0 = falls.size();
    send(16'hF800, 1'b0, a);
    send(16'h07E0, 1'b0, a2);
    send(16'h001F, 1'b0, a2);
    send(16'hFFFF, 1'b0, a2);
    bus.in_valid = 1'b0;
    wait_for(1, "burst_done");
    chk("burst_falls", falls.size() - nf0, 4);
    for (int k = 1; k < 4; k++) chk("burst_period", falls[nf0 + k] - falls[nf0 + k - 1], 5);
    chk("burst_cs_rises", cs_rises - c0, 1);
    chk("burst_sb_empty", sb.size(), 0);

    // Short upstream gap keeps CS low and skips SETUP
    c0 = cs_rises;
    send(16'h1111, 1'b0, a);
    bus.in_valid = 1'b0;
    wait_for(0, "gap3_hold");
    repeat (2) @(negedge clk);
    send(16'h2222, 1'b0, a2);
    bus.in_valid = 1'b0;
    wait_for(1, "gap3_done");
    chk("gap3_wr_fall", wr_fall_cyc - a2, 0);
    chk("gap3_cs_rises", cs_rises - c0, 1);

    // Long gap releases CS and the next word gets SETUP
    c0 = cs_rises;
    send(16'h3333, 1'b1, a);
    bus.in_valid = 1'b0;
    wait_for(0, "gap6_hold");
    repeat (6) @(negedge clk);
    send(16'h4444, 1'b0, a2);
    bus.in_valid = 1'b0;
    wait_for(1, "gap6_done");
    chk("gap6_cs_rises", cs_rises - c0, 2);
    chk("gap6_cs_fall", cs_fall_cyc - a2, 1);
    chk("gap6_wr_fall", wr_fall_cyc - a2, 2);
    chk("gap_sb_empty", sb.size(), 0);

    // panel_reset_req during WR_LOW
    send(16'hABCD, 1'b0, a);
    bus.in_valid = 1'b0;
    wait_for(2, "req_wr_low");
    f = cyc;
    chk("req_fall_at", f - a, 2);
    bus.panel_reset_req = 1'b1;
    @(negedge clk);
    bus.panel_reset_req = 1'b0;
    res_cyc   = -1;
    rdy_cyc   = -1;
    cs_at_res = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.lcd_res && res_cyc < 0) begin
        res_cyc   = cyc;
        cs_at_res = bus.lcd_cs;
      end
      if (bus.in_ready && rdy_cyc < 0) rdy_cyc = cyc;
      @(negedge clk);
    end
    chk("req_wr_rise", wr_rise_cyc - f, 2);
    chk("req_res_low", res_cyc - f, 4);
    chk("req_cs_at_res", 32'(cs_at_res), 1);
    chk("req_ready_back", rdy_cyc - f, 34);
    chk("req_sb_empty", sb.size(), 0);

    // Simultaneous in_valid and panel_reset_req in IDLE: reset wins
    nf0 = falls.size();
    chk("sim_ready_before", 32'(bus.in_ready), 1);
    bus.in_valid        = 1'b1;
    bus.in_data         = 16'h5A5A;
    bus.in_is_cmd       = 1'b0;
    bus.panel_reset_req = 1'b1;
    @(negedge clk);
    bus.in_valid        = 1'b0;
    bus.panel_reset_req = 1'b0;
    chk("sim_ready", 32'(bus.in_ready), 0);
    chk("sim_res", 32'(bus.lcd_res), 0);
    chk("sim_cs", 32'(bus.lcd_cs), 1);
    wait_for(0, "sim_ready_back");
    chk("sim_no_write", falls.size() - nf0, 0);

    // Asynchronous reset in the middle of WR_LOW
    send(16'h0F0F, 1'b1, a);
    bus.in_valid = 1'b0;
    wait_for(2, "arst_wr_low");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_wr", 32'(bus.lcd_wr), 1);
    chk("arst_cs", 32'(bus.lcd_cs), 1);
    chk("arst_res", 32'(bus.lcd_res), 0);
    chk("arst_data", 32'(bus.lcd_data), 0);
    chk("arst_ready", 32'(bus.in_ready), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    r = cyc;
    reset_n = 1'b1;
    measure_reset(r, "arst");

    // Normal operation after the rerun reset sequence
    send(16'h00AA, 1'b0, a);
    bus.in_valid = 1'b0;
    wait_for(1, "final_done");
    chk("final_wr_fall", wr_fall_cyc - a, 2);
    chk("final_data", 32'(bus.lcd_data), 32'hAA);
    chk("final_c_d", 32'(bus.lcd_c_d), 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
